// File: rtl/rob_pkg.sv
// Shared sizing constants and the reorder-buffer entry layout used by the
// commit logic and its pointer sub-module.
package rob_pkg;

   localparam int DEPTH  = 8;
   localparam int REG_W  = 4;
   localparam int DATA_W = 32;
   localparam int TAG_W  = $clog2(DEPTH);

   typedef struct packed {
      logic              valid;
      logic              done;
      logic [REG_W-1:0]  dest;
      logic [DATA_W-1:0] data;
   } rob_entry_t;

endpackage

// File: rtl/rob_ptr.sv
// Wrap-around index register used for both the head and tail of the
// reorder buffer: advances on inc, returns to zero on clear.
module rob_ptr #(
   parameter int DEPTH = rob_pkg::DEPTH,
   parameter int W     = $clog2(DEPTH)
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic         clear,
   input  logic         inc,
   output logic [W-1:0] ptr
);

   localparam logic [W-1:0] LAST = W'(DEPTH - 1);

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         ptr <= '0;
      end else if (clear) begin
         ptr <= '0;
      end else if (inc) begin
         ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
      end
   end

endmodule

// File: rtl/rob_commit.sv
// In-order retirement stage of a reorder buffer: entries are allocated at the
// tail, completed out of order by tag, and written to the ARF from the head.
module rob_commit #(
   parameter int DEPTH  = rob_pkg::DEPTH,
   parameter int REG_W  = rob_pkg::REG_W,
   parameter int DATA_W = rob_pkg::DATA_W,
   localparam int TAG_W = $clog2(DEPTH)
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              alloc_valid,
   input  logic [REG_W-1:0]  alloc_dest,
   output logic              alloc_ready,
   output logic [TAG_W-1:0]  alloc_tag,
   input  logic              cmpl_valid,
   input  logic [TAG_W-1:0]  cmpl_tag,
   input  logic [DATA_W-1:0] cmpl_data,
   input  logic              flush,
   output logic [REG_W-1:0]  write_reg,
   output logic              write_enable,
   output logic [DATA_W-1:0] write_data,
   output logic [TAG_W:0]    count,
   output logic              empty
);

   import rob_pkg::*;

   localparam logic [TAG_W:0] FULL = (TAG_W + 1)'(DEPTH);

   rob_entry_t       entries [DEPTH];
   rob_entry_t       head_entry;
   logic [TAG_W-1:0] head;
   logic [TAG_W-1:0] tail;
   logic             alloc_fire;
   logic             commit_fire;
   logic             cmpl_fire;

   assign head_entry  = entries[head];
   assign alloc_ready = (count != FULL);
   assign alloc_tag   = tail;
   assign empty       = (count == '0);

   // Flush outranks everything; a completion aimed at the slot being
   // allocated this edge belongs to a stale instruction and is dropped.
   assign alloc_fire  = alloc_valid && alloc_ready && !flush;
   assign commit_fire = head_entry.valid && head_entry.done && !flush;
   assign cmpl_fire   = cmpl_valid && !flush
                        && entries[cmpl_tag].valid && !entries[cmpl_tag].done
                        && !(alloc_fire && (cmpl_tag == tail));

   rob_ptr #(.DEPTH(DEPTH), .W(TAG_W)) head_ptr (
      .CLK   (CLK),
      .RESET (RESET),
      .clear (flush),
      .inc   (commit_fire),
      .ptr   (head)
   );

   rob_ptr #(.DEPTH(DEPTH), .W(TAG_W)) tail_ptr (
      .CLK   (CLK),
      .RESET (RESET),
      .clear (flush),
      .inc   (alloc_fire),
      .ptr   (tail)
   );

   // Entry storage: commit frees the head slot, completion marks a slot done,
   // allocation claims the tail slot.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      end else if (flush) begin
         for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      end else begin
         if (commit_fire) entries[head] <= '0;
         if (cmpl_fire) begin
            entries[cmpl_tag].done <= 1'b1;
            entries[cmpl_tag].data <= cmpl_data;
         end
         if (alloc_fire) begin
            entries[tail] <= '{valid: 1'b1, done: 1'b0, dest: alloc_dest, data: '0};
         end
      end
   end

   // Occupancy and the registered ARF write port; register 0 retires silently.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         count        <= '0;
         write_enable <= 1'b0;
         write_reg    <= '0;
         write_data   <= '0;
      end else if (flush) begin
         count        <= '0;
         write_enable <= 1'b0;
      end else begin
         unique case ({alloc_fire, commit_fire})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         write_enable <= commit_fire && (head_entry.dest != '0);
         if (commit_fire && (head_entry.dest != '0)) begin
            write_reg  <= head_entry.dest;
            write_data <= head_entry.data;
         end
      end
   end

endmodule

// File: doc/rob_commit.md
ROB_COMMIT -- requirements
Module: rob_commit

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning the number of reorder-buffer entries (power of two).
REQ-002 SHALL have parameter REG_W, default 4, meaning the width of the ARF register index.
REQ-003 SHALL have parameter DATA_W, default 32, meaning the width of the ARF write data.
REQ-004 SHALL have port CLK  input  1  the single clock; all state SHALL update on its rising edge.
REQ-005 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port alloc_valid  input  1  dispatch requests one entry in program order.
REQ-007 SHALL have port alloc_dest  input  REG_W  destination register of the dispatched instruction.
REQ-008 SHALL have port alloc_ready  output  1  high when count < DEPTH (combinational).
REQ-009 SHALL have port alloc_tag  output  log2(DEPTH)  current tail index, the tag of the next allocated entry.
REQ-010 SHALL have port cmpl_valid  input  1  an execution unit reports a result.
REQ-011 SHALL have port cmpl_tag  input  log2(DEPTH)  entry the result belongs to.
REQ-012 SHALL have port cmpl_data  input  DATA_W  result value.
REQ-013 SHALL have port flush  input  1  discard all in-flight entries.
REQ-014 SHALL have port write_reg  output  REG_W  ARF write index (registered).
REQ-015 SHALL have port write_enable  output  1  ARF write strobe, one cycle per retirement (registered).
REQ-016 SHALL have port write_data  output  DATA_W  ARF write value (registered).
REQ-017 SHALL have port count  output  log2(DEPTH)+1  number of valid entries.
REQ-018 SHALL have port empty  output  1  high when count == 0.

Function
REQ-019 Allocation SHALL occur at an edge where alloc_valid && alloc_ready: entry[tail] <= {valid=1, done=0, dest=alloc_dest}; tail wraps DEPTH-1 -> 0.
REQ-020 Completion SHALL set done and store cmpl_data only if entry[cmpl_tag] is valid and not done at that edge; otherwise it SHALL be ignored.
REQ-021 A completion targeting the entry being allocated in the same edge SHALL be ignored.
REQ-022 Commit SHALL occur at an edge where entry[head] is valid and done: next cycle write_enable=1, write_reg=dest, write_data=data; entry cleared; head wraps.
REQ-023 At most one commit per cycle, strictly in order; a not-done head SHALL block younger done entries.
REQ-024 A completion of the head entry SHALL commit no earlier than the following edge (minimum completion-to-write_enable latency 2 edges).
REQ-025 A committing entry with dest 0 SHALL retire and advance head with write_enable held 0 (x0 not written).
REQ-026 In cycles without a commit, write_enable SHALL be 0; write_reg/write_data hold their last values.
REQ-027 Simultaneous allocate and commit SHALL leave count unchanged; when full, alloc_ready=0 even if a commit occurs that edge.
REQ-028 Empty buffer: no commit, write_enable 0.
REQ-029 flush SHALL be synchronous and highest priority: all entries invalid, head=tail=0, count=0, write_enable=0 next cycle; same-edge alloc/cmpl ignored.

Reset
REQ-030 RESET high SHALL immediately clear all entries, head, tail, count, write_enable, write_reg and write_data to 0, regardless of CLK.
REQ-031 After RESET deasserts, alloc_ready=1, empty=1, alloc_tag=0.

Structure
REQ-032 Package rob_pkg SHALL hold DEPTH, REG_W, DATA_W, TAG_W=log2(DEPTH) and the entry struct {valid, done, dest, data}.
REQ-033 One sub-module rob_ptr (wrap-around pointer with increment enable and synchronous clear) SHALL be instantiated for head and tail.

Verification
REQ-034 Reset, alloc dest 2, cmpl tag 0 data ABCDEFAB -> write_enable=1, write_reg=2, write_data=ABCDEFAB for one cycle 2 edges after completion.
REQ-035 Alloc dest 4 (tag0), dest 5 (tag1); cmpl tag1 0x55 then tag0 0x44 -> writes reg4=0x44 then reg5=0x55 on consecutive cycles.
REQ-036 Allocate 8 entries without completion -> alloc_ready=0, count=8; 9th alloc_valid ignored, alloc_tag stays 0.
REQ-037 Fill 8, complete all, keep allocating during commits -> tail/head wrap 7 -> 0, count stays 8 then drains, 8 writes in order.
REQ-038 3 entries in flight, 1 completed, assert flush -> no write_enable, count=0, empty=1, next alloc gets tag 0.
REQ-039 Alloc dest 0, complete -> head advances, count decrements, write_enable stays 0.
